bsg_1_to_n_tagged_fifo_counted: RTL and testbench

- Demultiplexes one tagged input stream into num_out_p independent per-channel FIFOs, each with a guaranteed els_p entries.
- Adds per-channel occupancy counts, programmable almost-full flags and per-channel synchronous flush.
- Supports non-power-of-two depths and per-channel unbuffered pass-through.
- Sits between a multiplexed link receiver and per-channel consumers; the almost-full flags drive upstream credit or backpressure logic.

---
 rtl/bsg_1_to_n_tagged_fifo_counted.sv | 98 +++++++++
 tb/tb_bsg_1_to_n_tagged_fifo_counted.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bsg_1_to_n_tagged_fifo_counted.sv
// One tagged input stream demultiplexed into num_out_p per-channel FIFOs with
// occupancy counts, almost-full flags, per-channel flush and optional
// unbuffered pass-through channels.
module bsg_1_to_n_tagged_fifo_counted #(
  parameter int                   width_p              = 8,
  parameter int                   num_out_p            = 1,
  parameter int                   els_p                = 2,
  parameter int                   almost_full_thresh_p = els_p - 1,
  parameter logic [num_out_p-1:0] unbuffered_mask_p    = '0,
  parameter int                   tag_width_lp         = (num_out_p > 1) ? $clog2(num_out_p) : 1,
  parameter int                   ptr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int                   count_width_lp       = $clog2(els_p + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      v_i,
  input  logic [tag_width_lp-1:0]                   tag_i,
  input  logic [width_p-1:0]                        data_i,
  output logic                                      yumi_o,
  input  logic [num_out_p-1:0]                      flush_i,
  output logic [num_out_p-1:0]                      v_o,
  output logic [num_out_p-1:0][width_p-1:0]         data_o,
  input  logic [num_out_p-1:0]                      yumi_i,
  output logic [num_out_p-1:0][count_width_lp-1:0]  count_o,
  output logic [num_out_p-1:0]                      almost_full_o
);

  logic [num_out_p-1:0] sel;
  logic [num_out_p-1:0] ready;

  // One-hot channel select; an out-of-range tag matches no channel.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < num_out_p; i++) begin
      sel[i] = v_i & (tag_i == tag_width_lp'(i));
    end
  end

  assign yumi_o = ~reset_i & |(sel & ready);

  for (genvar g = 0; g < num_out_p; g++) begin : ch
    if (unbuffered_mask_p[g]) begin : passthru
      assign ready[g]         = 1'b1;
      assign v_o[g]           = sel[g];
      assign data_o[g]        = data_i;
      assign count_o[g]       = '0;
      assign almost_full_o[g] = 1'b0;
    end else begin : buffered
      logic [width_p-1:0]        mem [els_p];
      logic [ptr_width_lp-1:0]   rptr;
      logic [ptr_width_lp-1:0]   wptr;
      logic [count_width_lp-1:0] count;
      logic                      full;
      logic                      empty;
      logic                      enq;
      logic                      deq;

      // Modulo-els_p increment so non-power-of-two depths never address past the array.
      function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
      endfunction

      assign full     = (count == count_width_lp'(els_p));
      assign empty    = (count == '0);
      assign ready[g] = ~full & ~flush_i[g];
      assign enq      = sel[g] & ready[g] & ~reset_i;
      assign deq      = yumi_i[g];

      // Pointer and occupancy update; reset and flush take priority over traffic.
      always_ff @(posedge clk_i) begin
        if (reset_i | flush_i[g]) begin
          rptr  <= '0;
          wptr  <= '0;
          count <= '0;
        end else begin
          if (enq) wptr <= ptr_inc(wptr);
          if (deq) rptr <= ptr_inc(rptr);
          if (enq & ~deq)      count <= count + count_width_lp'(1);
          else if (~enq & deq) count <= count - count_width_lp'(1);
        end
      end

      // Storage write; contents need no reset since count gates visibility.
      always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
      end

      assign v_o[g]           = ~empty;
      assign data_o[g]        = mem[rptr];
      assign count_o[g]       = count;
      assign almost_full_o[g] = (count >= count_width_lp'(almost_full_thresh_p));

      a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
                                             yumi_i[g] |-> v_o[g]);
    end
  end

endmodule

// File: tb/tb_bsg_1_to_n_tagged_fifo_counted.sv
// Bench for bsg_1_to_n_tagged_fifo_counted: two instances (all-buffered and
// channel 2 pass-through) share stimulus and are compared to a queue model.
module tb_bsg_1_to_n_tagged_fifo_counted;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             v_i;
  logic [1:0]       tag_i;
  logic [7:0]       data_i;
  logic [2:0]       flush_i;
  logic [2:0]       yumi_i;
  logic             yumi_o_a, yumi_o_b;
  logic [2:0]       v_o_a, v_o_b;
  logic [2:0][7:0]  data_o_a, data_o_b;
  logic [2:0][1:0]  count_o_a, count_o_b;
  logic [2:0]       af_a, af_b;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per channel of the all-buffered instance.
  // Channels 0 and 1 behave identically in both instances.
  logic [7:0] mq [3][$];

  always #5 clk = ~clk;

  bsg_1_to_n_tagged_fifo_counted #(
    .width_p(8), .num_out_p(3), .els_p(3), .unbuffered_mask_p(3'b000)
  ) dut_a (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .tag_i(tag_i), .data_i(data_i),
    .yumi_o(yumi_o_a), .flush_i(flush_i), .v_o(v_o_a), .data_o(data_o_a),
    .yumi_i(yumi_i), .count_o(count_o_a), .almost_full_o(af_a)
  );

  bsg_1_to_n_tagged_fifo_counted #(
    .width_p(8), .num_out_p(3), .els_p(3), .unbuffered_mask_p(3'b100)
  ) dut_b (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .tag_i(tag_i), .data_i(data_i),
    .yumi_o(yumi_o_b), .flush_i(flush_i), .v_o(v_o_b), .data_o(data_o_b),
    .yumi_i(yumi_i), .count_o(count_o_b), .almost_full_o(af_b)
  );

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check all outputs against the model, then
  // advance the model across the rising edge.
  task automatic cycle(input logic rst, input logic v, input logic [1:0] tag,
                       input logic [7:0] d, input logic [2:0] fl, input logic [2:0] yu);
    logic ea, eb;
    int   sz;
    @(negedge clk);
    reset_i = rst; v_i = v; tag_i = tag; data_i = d; flush_i = fl; yumi_i = yu;
    #1;
    ea = !rst && v && (tag < 3) && !fl[tag] && (mq[tag].size() < 3);
    eb = !rst && v && ((tag == 2) || ((tag < 2) && !fl[tag] && (mq[tag].size() < 3)));
    check_eq("yumi_o_a", 32'(yumi_o_a), 32'(ea));
    check_eq("yumi_o_b", 32'(yumi_o_b), 32'(eb));
    for (int i = 0; i < 3; i++) begin
      sz = mq[i].size();
      check_eq($sformatf("v_o_a[%0d]", i), 32'(v_o_a[i]), 32'(sz > 0));
      check_eq($sformatf("count_a[%0d]", i), 32'(count_o_a[i]), 32'(sz));
      check_eq($sformatf("af_a[%0d]", i), 32'(af_a[i]), 32'(sz >= 2));
      if (sz > 0) check_eq($sformatf("data_a[%0d]", i), 32'(data_o_a[i]), 32'(mq[i][0]));
      if (i < 2) begin
        check_eq($sformatf("v_o_b[%0d]", i), 32'(v_o_b[i]), 32'(sz > 0));
        check_eq($sformatf("count_b[%0d]", i), 32'(count_o_b[i]), 32'(sz));
        check_eq($sformatf("af_b[%0d]", i), 32'(af_b[i]), 32'(sz >= 2));
        if (sz > 0) check_eq($sformatf("data_b[%0d]", i), 32'(data_o_b[i]), 32'(mq[i][0]));
      end else begin
        check_eq("v_o_b[2]", 32'(v_o_b[2]), 32'(v && tag == 2));
        check_eq("count_b[2]", 32'(count_o_b[2]), 32'd0);
        check_eq("af_b[2]", 32'(af_b[2]), 32'd0);
        if (v && tag == 2) check_eq("data_b[2]", 32'(data_o_b[2]), 32'(d));
      end
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (fl[i]) mq[i].delete();
        else if (yu[i]) void'(mq[i].pop_front());
      end
      if (ea) mq[tag].push_back(d);
    end
  endtask

  initial begin
    logic [2:0] yu, fl;
    reset_i = 1'b1; v_i = 1'b0; tag_i = '0; data_i = '0; flush_i = '0; yumi_i = '0;
    repeat (2) @(posedge clk);

    // Reset state
    cycle(0, 0, 0, 8'h00, 3'b000, 3'b000);

    // Fill channel 1 without dequeue; fourth word refused
    for (int k = 1; k <= 4; k++) cycle(0, 1, 1, 8'(8'h11 * k), 3'b000, 3'b000);
    cycle(0, 0, 0, 8'h00, 3'b000, 3'b000);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 8'h00, 3'b000, 3'b010);

    // Wrap-around on channel 0 with interleaved enqueue/dequeue
    for (int k = 1; k <= 7; k++) cycle(0, 1, 0, 8'(k), 3'b000, (mq[0].size() > 0) ? 3'b001 : 3'b000);
    cycle(0, 0, 0, 8'h00, 3'b000, 3'b001);
    cycle(0, 0, 0, 8'h00, 3'b000, 3'b000);

    // Full channel 2: enqueue refused in the same cycle as a dequeue, accepted next
    for (int k = 0; k < 3; k++) cycle(0, 1, 2, 8'(8'hC0 + k), 3'b000, 3'b000);
    cycle(0, 1, 2, 8'hC9, 3'b000, 3'b100);
    cycle(0, 1, 2, 8'hCA, 3'b000, 3'b000);

    // Flush channel 1 holding two entries with concurrent enqueue and dequeue
    cycle(0, 1, 1, 8'h51, 3'b000, 3'b000);
    cycle(0, 1, 1, 8'h52, 3'b000, 3'b000);
    cycle(0, 1, 0, 8'h61, 3'b000, 3'b000);
    cycle(0, 1, 1, 8'h53, 3'b010, 3'b010);
    cycle(0, 0, 0, 8'h00, 3'b000, 3'b000);

    // Pass-through channel 2 on the second instance; out-of-range tag
    cycle(0, 1, 2, 8'hAB, 3'b000, 3'b000);
    cycle(0, 1, 3, 8'hEE, 3'b000, 3'b000);

    // Mid-operation reset with all channels non-empty, then first enqueue
    cycle(0, 1, 1, 8'h71, 3'b000, 3'b000);
    cycle(1, 1, 0, 8'h72, 3'b000, 3'b000);
    cycle(0, 1, 0, 8'h99, 3'b000, 3'b000);
    cycle(0, 0, 0, 8'h00, 3'b000, 3'b000);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      yu = '0;
      fl = '0;
      for (int i = 0; i < 3; i++) begin
        yu[i] = ($urandom_range(0, 1) == 1) && (mq[i].size() > 0);
        fl[i] = ($urandom_range(0, 11) == 0);
      end
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom), fl, yu);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
